// File: rtl/usr_seq_ctrl_if.sv
// Command channel of the sequence controller.
// A command transfers on a rising clk edge where cmd_valid and cmd_ready are both high;
// cmd_ready may fall at any time, and a command offered while cmd_ready is low is simply dropped.
interface usr_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic [2:0] cmd_len;
    logic [3:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_dir,
        output cmd_len,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_dir,
        input  cmd_len,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Sequence controller driving a 4-bit universal shift register.
// Commands: NOP, TX (load then shift out), RX (shift in), LOAD (parallel load).
module usr_seq_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    usr_seq_ctrl_if.slave        cmd,
    input  logic                 sin,
    output logic [3:0]           q,
    output logic [1:0]           s,
    output logic                 sout,
    output logic                 sout_valid,
    output logic                 done,
    output logic [3:0]           rsp_data,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_TX   = 2'b01;
    localparam logic [1:0] OP_RX   = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_LEFT  = 2'b01;
    localparam logic [1:0] S_RIGHT = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] op_r;
    logic       dir_r;
    logic [2:0] len_r;
    logic [3:0] data_r;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic [3:0] q_nxt;
    logic [2:0] len_clamp;
    logic       accept;
    logic       fill;

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign accept        = cmd.cmd_valid && (state == ST_IDLE);
    assign len_clamp     = (cmd.cmd_len > 3'd4) ? 3'd4 : cmd.cmd_len;
    assign state_dbg     = state;
    // TX shifts zeros in behind the outgoing data; RX shifts the serial input in.
    assign fill          = (op_r == OP_RX) ? sin : 1'b0;

    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        cnt_nxt    = cnt;
        s          = S_HOLD;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    cnt_nxt = len_clamp;
                    case (cmd.cmd_op)
                        OP_TX, OP_LOAD: state_nxt = ST_LOAD;
                        OP_RX:          state_nxt = (len_clamp != 3'd0) ? ST_SHIFT : ST_DONE;
                        default:        state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_LOAD: begin
                s         = S_LOAD;
                q_nxt     = data_r;
                state_nxt = ((op_r == OP_TX) && (len_r != 3'd0)) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                s          = dir_r ? S_RIGHT : S_LEFT;
                // Serial output taken from the pre-shift register so the first bit leaves immediately.
                sout       = dir_r ? q[0] : q[3];
                sout_valid = (op_r == OP_TX);
                q_nxt      = dir_r ? {fill, q[3:1]} : {q[2:0], fill};
                cnt_nxt    = cnt - 3'd1;
                if (cnt <= 3'd1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            q        <= 4'b0000;
            rsp_data <= 4'b0000;
            op_r     <= OP_NOP;
            dir_r    <= 1'b0;
            len_r    <= 3'd0;
            data_r   <= 4'b0000;
            cnt      <= 3'd0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_r   <= cmd.cmd_op;
                dir_r  <= cmd.cmd_dir;
                len_r  <= len_clamp;
                data_r <= cmd.cmd_data;
            end
            // Capture on the edge entering DONE so rsp_data is already valid while done is high.
            if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
                rsp_data <= q_nxt;
            end
        end
    end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench for usr_seq_ctrl: command-level model producing the expected
// per-cycle outputs, a negedge compare process, and directed literal checks.
module tb_usr_seq_ctrl;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_TX   = 2'b01;
    localparam logic [1:0] OP_RX   = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic       clk;
    logic       rst;
    logic       sin;
    logic [3:0] q;
    logic [1:0] s;
    logic       sout;
    logic       sout_valid;
    logic       done;
    logic [3:0] rsp_data;
    logic [1:0] state_dbg;

    usr_seq_ctrl_if cmd_if ();

    usr_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .sin        (sin),
        .q          (q),
        .s          (s),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done),
        .rsp_data   (rsp_data),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // ---------------- scoreboard state ----------------
    // Expected entry: {q[3:0], s[1:0], sout, sout_valid, done, cmd_ready, rsp_data[3:0]}
    logic [13:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] m_q   = 4'b0000;
    logic [3:0] m_rsp = 4'b0000;

    // Observations used by the literal checks.
    logic [3:0] obs_bits  = 4'b0000;
    int         obs_n     = 0;
    int         acc_cyc   = 0;
    int         last_lat  = -1;
    logic [3:0] last_rsp  = 4'b0000;

    function automatic logic [13:0] pack(input logic [3:0] pq, input logic [1:0] ps,
                                         input logic so, input logic sv, input logic dn,
                                         input logic rdy, input logic [3:0] rsp);
        return {pq, ps, so, sv, dn, rdy, rsp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic [13:0] e;
        logic [13:0] a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                    acc_cyc  = cyc;
                    obs_bits = 4'b0000;
                    obs_n    = 0;
                end
                if (sout_valid) begin
                    obs_bits = {obs_bits[2:0], sout};
                    obs_n    = obs_n + 1;
                end
                if (done) begin
                    last_lat = cyc - acc_cyc;
                    last_rsp = rsp_data;
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a = pack(q, s, sout, sout_valid, done, cmd_if.cmd_ready, rsp_data);
                    n_vec = n_vec + 1;
                    if (a !== e) begin
                        n_miss = n_miss + 1;
                        $display("FAIL trace cyc=%0d got q=%b s=%b sout=%b sv=%b done=%b rdy=%b rsp=%b expected q=%b s=%b sout=%b sv=%b done=%b rdy=%b rsp=%b",
                                 cyc, a[13:10], a[9:8], a[7], a[6], a[5], a[4], a[3:0],
                                 e[13:10], e[9:8], e[7], e[6], e[5], e[4], e[3:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_if.cmd_valid = 1'b0;
            sin = 1'($urandom);
            exp_q.push_back(pack(m_q, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, m_rsp));
            @(posedge clk);
            #1;
        end
    endtask

    // Builds the whole expected cycle trace of one command from the command rules, then
    // drives it cycle by cycle. abort_at >= 0 pulses rst at the start of that cycle.
    task automatic do_cmd(input logic [1:0] op, input logic dir, input logic [2:0] len,
                          input logic [3:0] data, input bit noise, input bit use_pat,
                          input logic [3:0] pat, input int abort_at);
        logic [13:0] ent[$];
        logic        sinb[$];
        logic [3:0]  mq;
        logic        b;
        logic        fl;
        int          eff;
        eff = (len > 3'd4) ? 4 : int'(len);
        mq  = m_q;
        ent.push_back(pack(mq, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, m_rsp));
        sinb.push_back(1'($urandom));
        if (op == OP_TX || op == OP_LOAD) begin
            ent.push_back(pack(mq, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, m_rsp));
            sinb.push_back(1'($urandom));
            mq = data;
        end
        if ((op == OP_TX || op == OP_RX) && eff > 0) begin
            for (int k = 0; k < eff; k++) begin
                b = use_pat ? pat[3-k] : 1'($urandom);
                sinb.push_back(b);
                ent.push_back(pack(mq, dir ? 2'b10 : 2'b01, dir ? mq[0] : mq[3],
                                   op == OP_TX, 1'b0, 1'b0, m_rsp));
                fl = (op == OP_RX) ? b : 1'b0;
                mq = dir ? {fl, mq[3:1]} : {mq[2:0], fl};
            end
        end
        ent.push_back(pack(mq, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, mq));
        sinb.push_back(1'($urandom));

        for (int i = 0; i < ent.size(); i++) begin
            if (i == abort_at) begin
                cmd_if.cmd_valid = 1'b0;
                rst = 1'b1;
                #2;
                check("abort_q", 32'(q), 32'(4'b0000));
                check("abort_ready", 32'(cmd_if.cmd_ready), 32'd1);
                check("abort_done", 32'(done), 32'd0);
                check("abort_sv", 32'(sout_valid), 32'd0);
                check("abort_rsp", 32'(rsp_data), 32'(4'b0000));
                @(posedge clk);
                #1;
                rst   = 1'b0;
                m_q   = 4'b0000;
                m_rsp = 4'b0000;
                return;
            end
            exp_q.push_back(ent[i]);
            if (i == 0) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_op    = op;
                cmd_if.cmd_dir   = dir;
                cmd_if.cmd_len   = len;
                cmd_if.cmd_data  = data;
            end else begin
                cmd_if.cmd_valid = noise;
                cmd_if.cmd_op    = 2'($urandom);
                cmd_if.cmd_dir   = 1'($urandom);
                cmd_if.cmd_len   = 3'($urandom);
                cmd_if.cmd_data  = 4'($urandom);
            end
            sin = sinb[i];
            @(posedge clk);
            #1;
        end
        cmd_if.cmd_valid = 1'b0;
        m_q   = mq;
        m_rsp = mq;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst              = 1'b1;
        sin              = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_len   = 3'd0;
        cmd_if.cmd_data  = 4'b0000;
        #3;
        check("rst_q", 32'(q), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_sv", 32'(sout_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rsp", 32'(rsp_data), 32'd0);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // TX 1011 len 4 left: MSB-first 1,0,1,1; register drained to 0000.
        last_lat = -1;
        do_cmd(OP_TX, 1'b0, 3'd4, 4'b1011, 1'b0, 1'b0, 4'b0000, -1);
        check("tx_bits", 32'(obs_bits), 32'(4'b1011));
        check("tx_nbits", 32'(obs_n), 32'd4);
        check("tx_lat", 32'(last_lat), 32'd6);
        check("tx_rsp", 32'(last_rsp), 32'(4'b0000));
        check("tx_q", 32'(q), 32'(4'b0000));

        // RX right from 0000 with sin 1,1,0,1 -> 1011.
        last_lat = -1;
        do_cmd(OP_RX, 1'b1, 3'd4, 4'b0000, 1'b0, 1'b1, 4'b1101, -1);
        check("rx_rsp", 32'(last_rsp), 32'(4'b1011));
        check("rx_lat", 32'(last_lat), 32'd5);

        // TX len 0: load then done, nothing shifted out.
        last_lat = -1;
        do_cmd(OP_TX, 1'b0, 3'd0, 4'b0110, 1'b0, 1'b0, 4'b0000, -1);
        check("tx0_nbits", 32'(obs_n), 32'd0);
        check("tx0_rsp", 32'(last_rsp), 32'(4'b0110));
        check("tx0_lat", 32'(last_lat), 32'd2);

        // len 7 clamps to 4.
        last_lat = -1;
        do_cmd(OP_TX, 1'b0, 3'd7, 4'b1011, 1'b0, 1'b0, 4'b0000, -1);
        check("tx7_bits", 32'(obs_bits), 32'(4'b1011));
        check("tx7_nbits", 32'(obs_n), 32'd4);
        check("tx7_lat", 32'(last_lat), 32'd6);

        // cmd_valid held high throughout, alternating LOAD/NOP.
        for (int i = 0; i < 6; i++) begin
            logic [3:0] d;
            d = 4'($urandom);
            last_lat = -1;
            if (i % 2 == 0) begin
                do_cmd(OP_LOAD, 1'b0, 3'($urandom), d, 1'b1, 1'b0, 4'b0000, -1);
                check("ld_lat", 32'(last_lat), 32'd2);
                check("ld_rsp", 32'(last_rsp), 32'(d));
            end else begin
                do_cmd(OP_NOP, 1'b0, 3'($urandom), d, 1'b1, 1'b0, 4'b0000, -1);
                check("nop_lat", 32'(last_lat), 32'd1);
            end
        end

        // Reset during the 2nd SHIFT cycle of TX 1111: abort without a done pulse.
        last_lat = -1;
        do_cmd(OP_TX, 1'b0, 3'd4, 4'b1111, 1'b0, 1'b0, 4'b0000, 3);
        check("abort_nodone", 32'(last_lat), 32'hFFFF_FFFF);
        last_lat = -1;
        do_cmd(OP_LOAD, 1'b0, 3'd0, 4'b0101, 1'b0, 1'b0, 4'b0000, -1);
        check("post_abort_rsp", 32'(last_rsp), 32'(4'b0101));
        check("post_abort_lat", 32'(last_lat), 32'd2);

        // Randomized commands, gaps and ignored-command noise.
        for (int i = 0; i < 80; i++) begin
            idle_cycles($urandom_range(0, 2));
            do_cmd(2'($urandom), 1'($urandom), 3'($urandom), 4'($urandom),
                   1'($urandom), 1'b0, 4'b0000, -1);
        end
        idle_cycles(2);
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
